// File: rtl/spike_rate_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spike_rate_monitor
//  Purpose  : Observes the spike output of an upstream LIF neuron. It reports
//             the number of spike events (rising edges) per programmable
//             window and streams inter-spike intervals through a 4-entry
//             show-ahead FIFO.
//  Ports    : clk        - rising-edge clock
//             rst_n      - synchronous active-low reset
//             spike_in   - spike level from the neuron
//             win_len    - window length in cycles (0 means 256)
//             rate_out   - event count of the last completed window
//             rate_valid - one-cycle pulse when rate_out updates
//             isi_data   - interval at the FIFO head
//             isi_valid  - FIFO not empty
//             isi_ready  - consumer accepts isi_data
//             fifo_full  - FIFO holds 4 entries
//             overflow   - sticky: an interval was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module spike_rate_monitor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spike_in,
    input  logic [7:0] win_len,
    output logic [7:0] rate_out,
    output logic       rate_valid,
    output logic [7:0] isi_data,
    output logic       isi_valid,
    input  logic       isi_ready,
    output logic       fifo_full,
    output logic       overflow
);

    localparam logic [7:0] c_MAX8  = 8'hFF;
    localparam logic [2:0] c_DEPTH = 3'd4;

    // ---------------------------------------------------------------- state
    logic       spk_q;
    logic [7:0] wlen_q,     wlen_d;
    logic [7:0] win_cnt_q,  win_cnt_d;
    logic [7:0] spk_cnt_q,  spk_cnt_d;
    logic [7:0] rate_q,     rate_d;
    logic       rate_vld_q, rate_vld_d;
    logic [7:0] isi_cnt_q,  isi_cnt_d;
    logic       armed_q,    armed_d;
    logic [1:0] rd_ptr_q,   rd_ptr_d;
    logic [1:0] wr_ptr_q,   wr_ptr_d;
    logic [2:0] count_q,    count_d;
    logic       ovf_q,      ovf_d;
    logic [7:0] mem_q [4];

    // ------------------------------------------------------- decode helpers
    logic       w_event;
    logic       w_close;
    logic [7:0] w_last;
    logic [7:0] w_spk_sum;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_wr_en;

    assign w_event   = spike_in & ~spk_q;
    // win_len of 0 wraps to 255 here, giving a 256-cycle window for free.
    assign w_last    = wlen_q - 8'd1;
    assign w_close   = (win_cnt_q == w_last);
    assign w_spk_sum = (w_event && (spk_cnt_q != c_MAX8)) ? spk_cnt_q + 8'd1 : spk_cnt_q;

    assign w_full    = (count_q == c_DEPTH);
    assign w_pop     = (count_q != 3'd0) & isi_ready;
    // The very first event after reset only arms interval timing.
    assign w_push    = w_event & armed_q;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en   = w_push & (~w_full | w_pop);

    always_comb begin
        wlen_d     = wlen_q;
        win_cnt_d  = win_cnt_q + 8'd1;
        spk_cnt_d  = w_spk_sum;
        rate_d     = rate_q;
        rate_vld_d = 1'b0;
        isi_cnt_d  = isi_cnt_q;
        armed_d    = armed_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        // Window: the closing cycle's own event is included in the report.
        if (w_close) begin
            win_cnt_d  = 8'd0;
            spk_cnt_d  = 8'd0;
            rate_d     = w_spk_sum;
            rate_vld_d = 1'b1;
            wlen_d     = win_len;
        end

        // Interval timer restarts at 1 so an event three cycles later reads 3.
        if (w_event) begin
            armed_d   = 1'b1;
            isi_cnt_d = 8'd1;
        end else if (armed_q && (isi_cnt_q != c_MAX8)) begin
            isi_cnt_d = isi_cnt_q + 8'd1;
        end

        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (w_wr_en && !w_pop) begin
            count_d = count_q + 3'd1;
        end else if (!w_wr_en && w_pop) begin
            count_d = count_q - 3'd1;
        end
        if (w_push && w_full && !w_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spk_q      <= 1'b0;
            wlen_q     <= win_len;
            win_cnt_q  <= 8'd0;
            spk_cnt_q  <= 8'd0;
            rate_q     <= 8'd0;
            rate_vld_q <= 1'b0;
            isi_cnt_q  <= 8'd0;
            armed_q    <= 1'b0;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            ovf_q      <= 1'b0;
        end else begin
            spk_q      <= spike_in;
            wlen_q     <= wlen_d;
            win_cnt_q  <= win_cnt_d;
            spk_cnt_q  <= spk_cnt_d;
            rate_q     <= rate_d;
            rate_vld_q <= rate_vld_d;
            isi_cnt_q  <= isi_cnt_d;
            armed_q    <= armed_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: contents are only observable while isi_valid=1.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            mem_q[wr_ptr_q] <= isi_cnt_q;
        end
    end

    assign rate_out   = rate_q;
    assign rate_valid = rate_vld_q;
    assign isi_data   = mem_q[rd_ptr_q];
    assign isi_valid  = (count_q != 3'd0);
    assign fifo_full  = w_full;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spike_rate_monitor
//  Purpose  : Self-checking bench for spike_rate_monitor. Expected window
//             counts and intervals are queued as stimulus is driven and
//             compared when the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spike_rate_monitor;

    logic       clk;
    logic       rst_n;
    logic       spike_in;
    logic [7:0] win_len;
    logic [7:0] rate_out;
    logic       rate_valid;
    logic [7:0] isi_data;
    logic       isi_valid;
    logic       isi_ready;
    logic       fifo_full;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int rate_q[$];
    int isi_q[$];

    spike_rate_monitor u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spike_in  (spike_in),
        .win_len   (win_len),
        .rate_out  (rate_out),
        .rate_valid(rate_valid),
        .isi_data  (isi_data),
        .isi_valid (isi_valid),
        .isi_ready (isi_ready),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int want);
        n_checks++;
        if (obs != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] wl, input logic rdy);
        rst_n     = 1'b0;
        spike_in  = 1'b0;
        win_len   = wl;
        isi_ready = rdy;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic sb_empty(input string tag);
        chk({tag, "_rate_left"}, rate_q.size(), 0);
        chk({tag, "_isi_left"},  isi_q.size(),  0);
        rate_q.delete();
        isi_q.delete();
    endtask

    // Scoreboard: compare whatever the DUT presents against the queued values.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rate_valid) begin
                if (rate_q.size() == 0) chk("rate_unexpected", int'(rate_valid), 0);
                else chk("rate_out", int'(rate_out), rate_q.pop_front());
            end
            if (isi_valid && isi_ready) begin
                if (isi_q.size() == 0) chk("isi_unexpected", int'(isi_valid), 0);
                else chk("isi_data", int'(isi_data), isi_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; spike_in = 1'b0; win_len = 8'd0; isi_ready = 1'b0;

        // ---- window of 10, events at cycles 2,5,9; win_len change ignored
        do_reset(8'd10, 1'b1);
        chk("rst_rate_out",   int'(rate_out),   0);
        chk("rst_rate_valid", int'(rate_valid), 0);
        chk("rst_isi_valid",  int'(isi_valid),  0);
        chk("rst_fifo_full",  int'(fifo_full),  0);
        chk("rst_overflow",   int'(overflow),   0);
        rate_q.push_back(3);
        isi_q.push_back(3);
        isi_q.push_back(4);
        for (int c = 0; c < 10; c++) begin
            spike_in = (c == 2 || c == 5 || c == 9);
            if (c == 4) win_len = 8'd50;
            if (c == 9) chk("w10_no_early_valid", int'(rate_valid), 0);
            tick();
        end
        spike_in = 1'b0;
        chk("w10_valid", int'(rate_valid), 1);
        chk("w10_rate",  int'(rate_out),   3);
        tick();
        chk("w10_valid_one_cycle", int'(rate_valid), 0);
        chk("w10_rate_stable",     int'(rate_out),   3);
        sb_empty("w10");

        // ---- 256-cycle window: toggling, then held high for 50 cycles
        do_reset(8'd0, 1'b1);
        rate_q.push_back(128);
        for (int c = 0; c < 256; c++) begin
            spike_in = (c % 2 == 0);
            if (c % 2 == 0 && c > 0) isi_q.push_back(2);
            tick();
        end
        chk("w256_toggle_valid", int'(rate_valid), 1);
        chk("w256_toggle_rate",  int'(rate_out),   128);
        rate_q.push_back(1);
        isi_q.push_back(2);
        for (int c = 0; c < 256; c++) begin
            spike_in = (c < 50);
            tick();
        end
        spike_in = 1'b0;
        chk("w256_held_valid", int'(rate_valid), 1);
        chk("w256_held_rate",  int'(rate_out),   1);
        tick();
        sb_empty("w256");

        // ---- intervals 3, 7, 300 (saturates to 255)
        do_reset(8'd0, 1'b1);
        rate_q.push_back(3);
        isi_q.push_back(3);
        isi_q.push_back(7);
        isi_q.push_back(255);
        for (int c = 0; c <= 312; c++) begin
            if (c == 1) chk("isi_first_no_push", int'(isi_valid), 0);
            spike_in = (c == 0 || c == 3 || c == 10 || c == 310);
            tick();
        end
        spike_in = 1'b0;
        tick();
        sb_empty("isi_seq");

        // ---- no consumer: fill, overflow, then drain
        do_reset(8'd0, 1'b0);
        for (int c = 0; c <= 22; c++) begin
            if (c == 15) begin
                chk("fill_full",      int'(fifo_full), 1);
                chk("fill_no_ovf",    int'(overflow),  0);
                chk("fill_head",      int'(isi_data),  2);
            end
            if (c == 21) begin
                chk("ovf_set",        int'(overflow),  1);
                chk("ovf_still_full", int'(fifo_full), 1);
                chk("ovf_head_kept",  int'(isi_data),  2);
            end
            spike_in = (c == 0 || c == 2 || c == 5 || c == 9 || c == 14 || c == 20);
            tick();
        end
        spike_in = 1'b0;
        isi_q.push_back(2); isi_q.push_back(3); isi_q.push_back(4); isi_q.push_back(5);
        isi_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        isi_ready = 1'b0;
        chk("drain_empty",     int'(isi_valid), 0);
        chk("drain_ovf_stays", int'(overflow),  1);
        chk("drain_not_full",  int'(fifo_full), 0);
        sb_empty("drain");

        // ---- full FIFO, push coincides with pop
        do_reset(8'd0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            spike_in = (c == 0 || c == 2 || c == 5 || c == 9 || c == 14);
            tick();
        end
        chk("pp_full_before", int'(fifo_full), 1);
        isi_q.push_back(2);
        spike_in  = 1'b1;
        isi_ready = 1'b1;
        tick();
        spike_in  = 1'b0;
        isi_ready = 1'b0;
        chk("pp_full_after", int'(fifo_full), 1);
        chk("pp_no_ovf",     int'(overflow),  0);
        chk("pp_head",       int'(isi_data),  3);
        isi_q.push_back(3); isi_q.push_back(4); isi_q.push_back(5); isi_q.push_back(6);
        isi_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        isi_ready = 1'b0;
        chk("pp_drained", int'(isi_valid), 0);
        chk("pp_ovf_end", int'(overflow),  0);
        sb_empty("pp");

        // ---- reset mid-window with two FIFO entries
        do_reset(8'd4, 1'b0);
        rate_q.push_back(2);
        for (int c = 0; c < 6; c++) begin
            if (c == 5) chk("mid_rate_before", int'(rate_out), 2);
            spike_in = (c == 0 || c == 2 || c == 5);
            tick();
        end
        spike_in = 1'b0;
        chk("mid_fifo_valid", int'(isi_valid), 1);
        chk("mid_fifo_head",  int'(isi_data),  2);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_rate_out",   int'(rate_out),   0);
        chk("mid_rst_rate_valid", int'(rate_valid), 0);
        chk("mid_rst_isi_valid",  int'(isi_valid),  0);
        chk("mid_rst_fifo_full",  int'(fifo_full),  0);
        chk("mid_rst_overflow",   int'(overflow),   0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_abort_pulse", int'(rate_valid), 0);
        end
        rst_n = 1'b0;
        tick();
        sb_empty("mid");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
